system_x: RTL and testbench
===========================

# system_x

Three-input logic evaluator for the system-X Boolean function F = ~C & (~A | B), true for minterms 0 (000), 2 (010) and 6 (110) of {A,B,C}. F is driven combinationally. The block also provides a registered copy of F, single-cycle edge pulses, and a saturating count of clock cycles in which F is true. It sits between raw control inputs and downstream sequential logic.

## Interface
- CNT_W, default 16: width of the hit counter, 2..32.
- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  1  function input, MSB of the minterm index.
- B  input  1  function input, middle bit.
- C  input  1  function input, LSB.
- clear  input  1  synchronous clear of hit_count; active high.
- F  output  1  combinational F = ~C & (~A | B).
- F_q  output  1  F registered on clk.
- f_rise  output  1  one-cycle pulse when F_q goes 0->1.
- f_fall  output  1  one-cycle pulse when F_q goes 1->0.
- minterm  output  3  combinational {A,B,C}.
- hit_count  output  CNT_W  number of rising clk edges at which F was 1; saturating.

## Operation
- F is purely combinational and does not depend on clk or rst_n:
  - 1 for ABC = 000, 010 and 110.
  - 0 for ABC = 001, 011, 100, 101 and 111.
- minterm = {A,B,C}, combinational.
- Each rising clk edge with rst_n high:
  - F_q <= F.
  - prev <= F_q, where prev is an internal register.
  - f_rise = F_q & ~prev. f_fall = ~F_q & prev. Both are combinational from the registers.
- hit_count update at each rising clk edge:
  - If clear = 1, hit_count <= 0. Clear has priority over increment.
  - Otherwise, if F = 1 and hit_count is below 2^CNT_W-1, hit_count <= hit_count + 1.
  - Otherwise, hit_count holds.
- Saturation: at all-ones, hit_count holds until cleared or reset.
- rst_n low forces immediately, independent of clk:
  - F_q = 0, prev = 0, hit_count = 0.
  - As a result, f_rise = 0 and f_fall = 0.
- F and minterm stay live during reset.
- Reset released while F = 1: the first edge sets F_q = 1 and produces f_rise for one cycle.

## Timing
- F and minterm: zero-cycle combinational path from A, B and C.
- F_q: 1-cycle latency from F.
- f_rise and f_fall: valid in the cycle after the F_q transition edge, one cycle wide.
- hit_count: the increment is visible after the edge that samples F = 1.
- Reset assertion is asynchronous. Deassertion is expected synchronous to clk, so no edge is sampled while rst_n is low.
- Input glitches between clock edges affect only F and minterm, never the registered outputs.

## Test plan
- Exhaustive truth table:
  - Apply ABC 000,001,...,111, then 000, holding each 10 ns.
  - Required F sequence: 1,0,1,0,0,0,1,0,1.
  - minterm must equal the ABC index at every step.
- Registered path:
  - After reset, hold ABC = 000 for 1 clk.
  - Required: F_q = 1 and f_rise = 1 for exactly one cycle.
  - Then apply ABC = 001. Required: F_q = 0 after 1 clk and f_fall pulses once.
- Counter:
  - Hold ABC = 010 for 5 edges, then 111 for 3 edges.
  - Required: hit_count = 5 and stays 5.
  - Pulse clear for 1 edge. Required: hit_count = 0.
- Saturation:
  - With CNT_W = 2, hold F = 1 for 6 edges. Required: hit_count = 3.
  - Assert clear and F = 1 at the same edge. Required: hit_count = 0.
- Asynchronous reset mid-operation:
  - With hit_count = 4 and F_q = 1, drop rst_n between edges.
  - Required: F_q = 0 and hit_count = 0 immediately, no pulses, and F still equal to the combinational value.

Source files
------------

// File: rtl/system_x.sv
// system_x: evaluator for F = ~C & (~A | B), true for minterms 0, 2 and 6 of {A,B,C}.
//
// Parameters:
//   CNT_W      width of the saturating hit counter (2..32)
// Ports:
//   clk        rising-edge clock for all registered outputs
//   rst_n      asynchronous active-low reset
//   A, B, C    function inputs; A is the MSB of the minterm index
//   clear      synchronous clear of hit_count, priority over increment
//   F          combinational function value
//   F_q        F registered on clk
//   f_rise     one-cycle pulse after F_q goes 0->1
//   f_fall     one-cycle pulse after F_q goes 1->0
//   minterm    combinational {A,B,C}
//   hit_count  saturating count of rising edges that sampled F = 1
module system_x #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             clear,
  output logic             F,
  output logic             F_q,
  output logic             f_rise,
  output logic             f_fall,
  output logic [2:0]       minterm,
  output logic [CNT_W-1:0] hit_count
);

  logic prev;

  assign F       = ~C & (~A | B);
  assign minterm = {A, B, C};

  // Edge pulses compare the registered value against its one-cycle-old copy,
  // so they are glitch-free with respect to A/B/C.
  assign f_rise = F_q & ~prev;
  assign f_fall = ~F_q & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q  <= 1'b0;
      prev <= 1'b0;
    end else begin
      F_q  <= F;
      prev <= F_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clear) begin
      hit_count <= '0;
    end else if (F && (hit_count != '1)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_system_x.sv
module tb_system_x;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       A, B, C, clear;

  logic       F, F_q, f_rise, f_fall;
  logic [2:0] minterm;
  logic [15:0] hit_count;

  logic       F2, F_q2, f_rise2, f_fall2;
  logic [2:0] minterm2;
  logic [1:0] hit_count2;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int unsigned m_fq, m_prev, m_cnt, m_cnt2;

  always #5 clk = ~clk;

  system_x #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .clear(clear),
    .F(F), .F_q(F_q), .f_rise(f_rise), .f_fall(f_fall),
    .minterm(minterm), .hit_count(hit_count)
  );

  system_x #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .clear(clear),
    .F(F2), .F_q(F_q2), .f_rise(f_rise2), .f_fall(f_fall2),
    .minterm(minterm2), .hit_count(hit_count2)
  );

  // F is true exactly for minterms 0, 2 and 6.
  function automatic int unsigned f_ref(input int unsigned idx);
    return (idx == 0 || idx == 2 || idx == 6) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    int unsigned idx;
    idx = {A, B, C};
    chk("F", {31'd0, F}, f_ref(idx));
    chk("minterm", {29'd0, minterm}, idx);
    chk("F_w2", {31'd0, F2}, f_ref(idx));
  endtask

  task automatic chk_regs();
    chk("F_q", {31'd0, F_q}, m_fq);
    chk("f_rise", {31'd0, f_rise}, (m_fq == 1 && m_prev == 0) ? 1 : 0);
    chk("f_fall", {31'd0, f_fall}, (m_fq == 0 && m_prev == 1) ? 1 : 0);
    chk("hit_count", {16'd0, hit_count}, m_cnt);
    chk("hit_count_w2", {30'd0, hit_count2}, m_cnt2);
    chk("F_q_w2", {31'd0, F_q2}, m_fq);
  endtask

  // Apply inputs, check the combinational path, then take one clock edge,
  // advance the model and check the registered outputs.
  task automatic step(input logic [2:0] abc, input logic clr);
    int unsigned f;
    {A, B, C} = abc;
    clear = clr;
    #1;
    chk_comb();
    f = f_ref(abc);
    @(posedge clk);
    m_prev = m_fq;
    m_fq   = f;
    if (clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (f == 1) begin
      if (m_cnt  < 65535) m_cnt++;
      if (m_cnt2 < 3)     m_cnt2++;
    end
    #1;
    chk_regs();
  endtask

  initial begin
    rst_n = 1'b0;
    {A, B, C} = 3'b000;
    clear = 1'b0;
    m_fq = 0; m_prev = 0; m_cnt = 0; m_cnt2 = 0;
    #2;
    chk_regs();
    chk_comb();
    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: rise after reset release with F = 1, then fall.
    step(3'b000, 1'b0);
    chk("rise_after_reset", {31'd0, f_rise}, 1);
    step(3'b000, 1'b0);
    chk("rise_one_cycle", {31'd0, f_rise}, 0);
    step(3'b001, 1'b0);
    chk("fall_pulse", {31'd0, f_fall}, 1);
    step(3'b001, 1'b0);
    chk("fall_one_cycle", {31'd0, f_fall}, 0);

    // Exhaustive truth table, ending back at 000.
    for (int unsigned i = 0; i < 9; i++) step(3'(i % 8), 1'b0);

    // Counter: five hits, three misses, then clear.
    step(3'b111, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step(3'b010, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(3'b111, 1'b0);
    chk("count_five", {16'd0, hit_count}, 5);
    chk("count_w2_saturated", {30'd0, hit_count2}, 3);
    step(3'b111, 1'b1);
    chk("count_cleared", {16'd0, hit_count}, 0);

    // Saturation on the narrow instance, then clear beating increment.
    for (int unsigned i = 0; i < 6; i++) step(3'b110, 1'b0);
    chk("sat_w2", {30'd0, hit_count2}, 3);
    step(3'b000, 1'b1);
    chk("clear_priority", {30'd0, hit_count2}, 0);

    // Asynchronous reset with hit_count = 4 and F_q = 1.
    for (int unsigned i = 0; i < 4; i++) step(3'b010, 1'b0);
    chk("pre_reset_count", {16'd0, hit_count}, 4);
    #2;
    rst_n = 1'b0;
    m_fq = 0; m_prev = 0; m_cnt = 0; m_cnt2 = 0;
    #1;
    chk_regs();
    chk_comb();
    {A, B, C} = 3'b011;
    #1;
    chk_comb();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional clears.
    for (int unsigned i = 0; i < 300; i++)
      step(3'($urandom_range(7)), ($urandom_range(7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
